// File: rtl/cdctl_pll_rst_seq_pkg.sv
// rtl/cdctl_pll_rst_seq_pkg.sv - state encoding and counter-width helper for the PLL reset sequencer
//
// Purpose : shared definitions for cdctl_pll_rst_seq and cdctl_rst_stage.
// Contents: pll_state_t  - sequencer states (glitch, wait, release ramp, run)
//           max3()       - largest of three integers
//           cnt_width()  - width of the shared phase counter
package cdctl_pll_rst_seq_pkg;

  typedef enum logic [1:0] {
    S_GLITCH = 2'd0,
    S_WAIT   = 2'd1,
    S_SEQ    = 2'd2,
    S_RUN    = 2'd3
  } pll_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The counter must be able to hold the longest phase terminal value:
  // GLITCH_LEN in the glitch phase, and the full release ramp in S_SEQ.
  function automatic int cnt_width(input int glitch_len, input int lock_delay,
                                   input int n_rst, input int stage_gap);
    return $clog2(max3(glitch_len, lock_delay, n_rst * stage_gap) + 1);
  endfunction

endpackage

// File: rtl/cdctl_rst_stage.sv
// rtl/cdctl_rst_stage.sv - single release flop of the sequenced reset ramp
//
// Purpose : drives one active-low domain reset. Sets once the shared phase
//           counter reaches REL_AT-1 during the release ramp, holds until a
//           lock loss or RESET.
// Ports   : i_clk   in  1   reference clock
//           i_rst   in  1   asynchronous active-high reset
//           i_clr   in  1   lock loss; dominates a same-cycle set
//           i_en    in  1   high while the sequencer is in the release ramp
//           i_cnt   in  CW  shared phase counter
//           o_rst_n out 1   registered active-low reset (1 = released)
module cdctl_rst_stage
  import cdctl_pll_rst_seq_pkg::*;
#(
  parameter int CW     = 4,
  parameter int REL_AT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [CW-1:0] i_cnt,
  output logic          o_rst_n
);

  // The counter reads REL_AT-1 in the cycle before the REL_AT-th edge after
  // lock rose, so the flop sets exactly on that edge.
  localparam logic [CW-1:0] L_HIT = CW'(REL_AT - 1);

  logic r_rel;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rel <= 1'b0;
    end else if (i_clr) begin
      r_rel <= 1'b0;
    end else if (i_en && (i_cnt == L_HIT)) begin
      r_rel <= 1'b1;
    end
  end

  assign o_rst_n = r_rel;

endmodule

// File: rtl/cdctl_pll_rst_seq.sv
// rtl/cdctl_pll_rst_seq.sv - PLL simulation model with ordered domain reset release
//
// Purpose : passes the reference clock through as the global PLL output,
//           emulates the power-up LOCK glitch and a programmable lock time,
//           then releases N_RST active-low resets STAGE_GAP cycles apart.
//           UNLOCK_REQ injects a lock loss and restarts the lock/release sequence.
// Ports   : REFERENCECLK in  1      the only clock, rising edge
//           RESET        in  1      asynchronous active-high reset
//           UNLOCK_REQ   in  1      synchronous level, forces loss of lock
//           PLLOUTGLOBAL out 1      combinational copy of REFERENCECLK
//           LOCK         out 1      registered lock indicator
//           RST_N        out N_RST  registered active-low resets, bit 0 released first
//           READY        out 1      registered, high when every RST_N bit is released
module cdctl_pll_rst_seq
  import cdctl_pll_rst_seq_pkg::*;
#(
  parameter int GLITCH_LEN = 2,
  parameter int LOCK_DELAY = 5,
  parameter int N_RST      = 3,
  parameter int STAGE_GAP  = 4
) (
  input  logic             REFERENCECLK,
  input  logic             RESET,
  input  logic             UNLOCK_REQ,
  output logic             PLLOUTGLOBAL,
  output logic             LOCK,
  output logic [N_RST-1:0] RST_N,
  output logic             READY
);

  localparam int CW = cnt_width(GLITCH_LEN, LOCK_DELAY, N_RST, STAGE_GAP);

  localparam logic [CW-1:0] L_CNT_MAX    = '1;
  localparam logic [CW-1:0] L_GLITCH_END = CW'(GLITCH_LEN);
  localparam logic [CW-1:0] L_WAIT_END   = CW'(LOCK_DELAY - 1);
  localparam logic [CW-1:0] L_SEQ_END    = CW'(N_RST * STAGE_GAP - 1);

  localparam pll_state_t L_RST_STATE = (GLITCH_LEN == 0) ? S_WAIT : S_GLITCH;

  generate
    if (LOCK_DELAY < 1) begin : g_bad_lock_delay
      $error("cdctl_pll_rst_seq: LOCK_DELAY must be >= 1");
    end
    if (N_RST < 1) begin : g_bad_n_rst
      $error("cdctl_pll_rst_seq: N_RST must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_stage_gap
      $error("cdctl_pll_rst_seq: STAGE_GAP must be >= 1");
    end
  endgenerate

  pll_state_t       r_state;
  pll_state_t       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_lock;
  logic             r_ready;
  logic             w_lock_nxt;
  logic             w_hold_clr;
  logic             w_lock_loss;
  logic             w_cnt_clr;
  logic             w_seq_en;
  logic [N_RST-1:0] w_rst_n;

  always_ff @(posedge REFERENCECLK or posedge RESET) begin
    if (RESET) begin
      r_state <= L_RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = 1'b0;
    w_hold_clr  = 1'b0;
    w_lock_loss = 1'b0;
    unique case (r_state)
      S_GLITCH: begin
        // LOCK is falsely high while the glitch lasts; an unlock request
        // abandons the remainder and starts the real lock wait.
        if (UNLOCK_REQ || (r_cnt == L_GLITCH_END)) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_lock_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        // Holding UNLOCK_REQ pins the lock timer at zero.
        if (UNLOCK_REQ) begin
          w_hold_clr = 1'b1;
        end else if (r_cnt == L_WAIT_END) begin
          w_state_nxt = S_SEQ;
          w_lock_nxt  = 1'b1;
        end
      end
      S_SEQ: begin
        if (UNLOCK_REQ) begin
          w_state_nxt = S_WAIT;
          w_lock_loss = 1'b1;
        end else begin
          w_lock_nxt = 1'b1;
          if (r_cnt == L_SEQ_END) begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (UNLOCK_REQ) begin
          w_state_nxt = S_WAIT;
          w_lock_loss = 1'b1;
        end else begin
          w_lock_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_WAIT;
      end
    endcase
  end

  assign w_cnt_clr = (w_state_nxt != r_state) || w_hold_clr;
  assign w_seq_en  = (r_state == S_SEQ);

  // Shared phase counter: restarts on every state change, saturates in S_RUN.
  always_ff @(posedge REFERENCECLK or posedge RESET) begin
    if (RESET) begin
      r_cnt   <= '0;
      r_lock  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_cnt != L_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_lock  <= w_lock_nxt;
      r_ready <= (w_state_nxt == S_RUN);
    end
  end

  for (genvar k = 0; k < N_RST; k++) begin : g_stage
    cdctl_rst_stage #(
      .CW    (CW),
      .REL_AT((k + 1) * STAGE_GAP)
    ) u_stage (
      .i_clk  (REFERENCECLK),
      .i_rst  (RESET),
      .i_clr  (w_lock_loss),
      .i_en   (w_seq_en),
      .i_cnt  (r_cnt),
      .o_rst_n(w_rst_n[k])
    );
  end

  assign PLLOUTGLOBAL = REFERENCECLK;
  assign LOCK         = r_lock;
  assign RST_N        = w_rst_n;
  assign READY        = r_ready;

  a_rst_thermo: assert property (@(posedge REFERENCECLK) disable iff (RESET)
    ((RST_N >> 1) & ~RST_N) == '0);
  a_rst_needs_lock: assert property (@(posedge REFERENCECLK) disable iff (RESET)
    (|RST_N) |-> LOCK);
  a_ready_all: assert property (@(posedge REFERENCECLK) disable iff (RESET)
    READY == (&RST_N));

endmodule

// File: tb/tb_cdctl_pll_rst_seq.sv
// tb/tb_cdctl_pll_rst_seq.sv - self-checking bench for the PLL reset sequencer
module tb_cdctl_pll_rst_seq;

  // Instance 0: defaults. Instance 1: minimal timing. Instance 2: wide ramp, random faults.
  localparam int P_G  [3] = '{2, 0, 2};
  localparam int P_LD [3] = '{5, 1, 100};
  localparam int P_N  [3] = '{3, 1, 8};
  localparam int P_GAP[3] = '{4, 1, 16};

  logic       clk = 1'b0;
  logic [2:0] rst_v = 3'b111;
  logic [2:0] unl_v = 3'b000;
  logic       check_en = 1'b0;

  logic       pll0, lk0, rd0;
  logic [2:0] rn0;
  logic       pll1, lk1, rd1;
  logic [0:0] rn1;
  logic       pll2, lk2, rd2;
  logic [7:0] rn2;

  int checks = 0;
  int errors = 0;

  // Model: edges since reset release, edge at which the current lock wait began,
  // and whether the power-up glitch is still pending.
  int m_e [3] = '{0, 0, 0};
  int m_ws[3] = '{0, 0, 0};
  bit m_gl[3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  cdctl_pll_rst_seq u_dut0 (
    .REFERENCECLK(clk), .RESET(rst_v[0]), .UNLOCK_REQ(unl_v[0]),
    .PLLOUTGLOBAL(pll0), .LOCK(lk0), .RST_N(rn0), .READY(rd0)
  );

  cdctl_pll_rst_seq #(.GLITCH_LEN(0), .LOCK_DELAY(1), .N_RST(1), .STAGE_GAP(1)) u_dut1 (
    .REFERENCECLK(clk), .RESET(rst_v[1]), .UNLOCK_REQ(unl_v[1]),
    .PLLOUTGLOBAL(pll1), .LOCK(lk1), .RST_N(rn1), .READY(rd1)
  );

  cdctl_pll_rst_seq #(.GLITCH_LEN(2), .LOCK_DELAY(100), .N_RST(8), .STAGE_GAP(16)) u_dut2 (
    .REFERENCECLK(clk), .RESET(rst_v[2]), .UNLOCK_REQ(unl_v[2]),
    .PLLOUTGLOBAL(pll2), .LOCK(lk2), .RST_N(rn2), .READY(rd2)
  );

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Expected {READY, LOCK, RST_N[7:0]} from the timeline rules.
  function automatic int model_out(input int i);
    logic [7:0] r;
    logic       lk;
    logic       rd;
    int         rise;
    r    = '0;
    rise = m_ws[i] + P_LD[i];
    lk   = (m_gl[i] && m_e[i] >= 1 && m_e[i] <= P_G[i]) || (m_e[i] >= rise);
    for (int k = 0; k < P_N[i]; k++) r[k] = (m_e[i] >= rise + (k + 1) * P_GAP[i]);
    rd   = (m_e[i] >= rise + P_N[i] * P_GAP[i]);
    return int'({rd, lk, r});
  endfunction

  function automatic int get_act(input int i);
    case (i)
      0:       return int'({rd0, lk0, 5'b0, rn0});
      1:       return int'({rd1, lk1, 7'b0, rn1});
      default: return int'({rd2, lk2, rn2});
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_v[i]) begin
        m_e[i]  <= 0;
        m_gl[i] <= (P_G[i] > 0);
        m_ws[i] <= (P_G[i] > 0) ? P_G[i] + 1 : 0;
      end else begin
        m_e[i] <= m_e[i] + 1;
        if (unl_v[i]) begin
          m_ws[i] <= m_e[i] + 1;
          m_gl[i] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (check_en) begin
      for (int i = 0; i < 3; i++) begin
        check("model", i, get_act(i), rst_v[i] ? 0 : model_out(i));
      end
      check("pllout_low", 0, int'({pll2, pll1, pll0}), 0);
      check("inv_thermo", 2, int'((rn2 >> 1) & ~rn2), 0);
      check("inv_lock", 2, int'((|rn2) && !lk2), 0);
      check("inv_ready", 2, int'(rd2), int'(&rn2));
    end
  end

  always @(posedge clk) begin
    #1;
    if (check_en) check("pllout_high", 0, int'({pll2, pll1, pll0}), 7);
  end

  // Full power-up sequence of instance 0, edges counted from RESET release.
  task automatic t1_ramp(input string tag);
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_lock"}, e, int'(lk0), (e <= 2 || e >= 8) ? 1 : 0);
      check({tag, "_rst_n"}, e, int'(rn0), (e >= 20) ? 7 : (e >= 16) ? 3 : (e >= 12) ? 1 : 0);
      check({tag, "_ready"}, e, int'(rd0), (e >= 20) ? 1 : 0);
    end
  endtask

  task automatic run_inst0();
    @(negedge clk);
    check("rst_state", 0, int'({rd0, lk0, rn0}), 0);
    rst_v[0] = 1'b0;
    t1_ramp("t1");

    // Single-cycle lock loss while running.
    unl_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    unl_v[0] = 1'b0;
    check("t3_drop", 0, int'({rd0, lk0, rn0}), 0);
    for (int j = 1; j <= 17; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 1)  check("t3_noglitch", j, int'(lk0), 0);
      if (j == 4)  check("t3_lock", j, int'(lk0), 0);
      if (j == 5)  check("t3_relock", j, int'({lk0, rn0}), 4'b1000);
      if (j == 9)  check("t3_rst_n", j, int'(rn0), 1);
      if (j == 16) check("t3_ramp", j, int'({rd0, rn0}), 4'b0011);
      if (j == 17) check("t3_ready", j, int'({rd0, lk0, rn0}), 5'b11111);
    end

    // RESET in the middle of the release ramp.
    rst_v[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_v[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("t4_pre", 0, int'(rn0), 1);
    @(posedge clk);
    #3;
    rst_v[0] = 1'b1;
    #1;
    check("t4_async", 0, int'({rd0, lk0, rn0}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_v[0] = 1'b0;
    t1_ramp("t4");

    // UNLOCK_REQ held during the lock wait.
    rst_v[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    unl_v[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("t5_held", j, int'(lk0), 0);
    end
    unl_v[0] = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check("t5_lock", j, int'(lk0), (j == 5) ? 1 : 0);
    end
  endtask

  task automatic run_inst1();
    @(negedge clk);
    check("t2_rst", 0, int'({rd1, lk1, rn1}), 0);
    rst_v[1] = 1'b0;
    @(negedge clk);
    check("t2_edge1", 1, int'({rd1, lk1, rn1}), 3'b010);
    @(negedge clk);
    check("t2_edge2", 2, int'({rd1, lk1, rn1}), 3'b111);
    repeat (5) @(negedge clk);
    unl_v[1] = 1'b1;
    @(negedge clk);
    unl_v[1] = 1'b0;
    check("t2_unlock", 0, int'({rd1, lk1, rn1}), 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic run_inst2();
    @(negedge clk);
    rst_v[2] = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_v[2] = ($urandom_range(0, 1499) == 0) || (c == 1000);
      unl_v[2] = ($urandom_range(0, 499) == 0) || (c == 400) || (c == 1150);
    end
    rst_v[2] = 1'b0;
    unl_v[2] = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    fork
      run_inst0();
      run_inst1();
      run_inst2();
    join
    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
